// File: rtl/ip_codma_states_pkg.sv
// Shared types, constants and small decode helpers for the descriptor-driven copy DMA.
package ip_codma_states_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 256;

  typedef enum logic [3:0] {
    StIdle,
    StFetch,
    StDecode,
    StRead,
    StWrite,
    StLink,
    StStatus,
    StError,
    StDone
  } dma_state_t;

  localparam logic [31:0] TASK_COPY8  = 32'd0;
  localparam logic [31:0] TASK_COPY32 = 32'd1;
  localparam logic [31:0] TASK_LINK32 = 32'd2;
  localparam logic [31:0] TASK_LINK8  = 32'd3;

  localparam logic [1:0]  SIZE_8B    = 2'd0;
  localparam logic [1:0]  SIZE_32B   = 2'd1;
  localparam logic [63:0] STATUS_OK  = 64'd0;
  localparam logic [63:0] STATUS_ERR = 64'd1;
  localparam logic [2:0]  MAX_DEPTH  = 3'd4;

  // Low 160 bits of the 32B descriptor fetch; w0 sits at the lowest address.
  typedef struct packed {
    logic [31:0] link;
    logic [31:0] dest;
    logic [31:0] src;
    logic [31:0] len_bytes;
    logic [31:0] task_type;
  } desc_t;

  function automatic logic task_valid(logic [31:0] task_type);
    return (task_type == TASK_COPY8) || (task_type == TASK_COPY32) ||
           (task_type == TASK_LINK32) || (task_type == TASK_LINK8);
  endfunction

  function automatic logic [31:0] chunk_bytes(logic [31:0] task_type);
    return ((task_type == TASK_COPY32) || (task_type == TASK_LINK32)) ? 32'd32 : 32'd8;
  endfunction

  function automatic logic task_linked(logic [31:0] task_type);
    return (task_type == TASK_LINK32) || (task_type == TASK_LINK8);
  endfunction

endpackage

// File: rtl/ip_codma_if.sv
// CPU control and memory bus interfaces of the copy DMA. On the bus the DMA is the master;
// on the CPU side the CPU is the master and the DMA the slave.
interface ip_codma_cpu_if;
  import ip_codma_states_pkg::*;

  logic              start;
  logic              stop;
  logic [ADDR_W-1:0] task_pointer;
  logic [ADDR_W-1:0] status_pointer;
  logic              busy;
  logic              irq;

  modport master (output start, stop, task_pointer, status_pointer, input busy, irq);
  modport slave  (input start, stop, task_pointer, status_pointer, output busy, irq);
endinterface

interface ip_codma_bus_if;
  import ip_codma_states_pkg::*;

  logic [ADDR_W-1:0] addr;
  logic              read_valid;
  logic              write_valid;
  logic [1:0]        size;
  logic [DATA_W-1:0] write_data;
  logic              grant;
  logic              read_data_valid;
  logic [DATA_W-1:0] read_data;
  logic              error;

  modport master (output addr, read_valid, write_valid, size, write_data,
                  input grant, read_data_valid, read_data, error);
  modport slave  (input addr, read_valid, write_valid, size, write_data,
                  output grant, read_data_valid, read_data, error);
endinterface

// File: rtl/ip_codma_main_machine.sv
// Control FSM of the copy DMA: next-state and output decode only; the state register and the
// datapath live in the top.
module ip_codma_main_machine
  import ip_codma_states_pkg::*;
(
  input  dma_state_t state_i,
  input  logic       pend_i,
  input  logic       start_rise_i,
  input  logic       stop_i,
  input  logic       grant_i,
  input  logic       rdata_valid_i,
  input  logic       bus_err_i,
  input  logic       type_ok_i,
  input  logic       len_zero_i,
  input  logic       len_misaligned_i,
  input  logic       last_chunk_i,
  input  logic       linked_i,
  input  logic       depth_max_i,
  output dma_state_t state_d_o,
  output logic       pend_d_o,
  output logic       read_valid_o,
  output logic       write_valid_o,
  output logic       busy_o,
  output logic       irq_o,
  output logic       accept_o,
  output logic       desc_load_o,
  output logic       buf_load_o,
  output logic       advance_o,
  output logic       link_load_o,
  output logic       err_set_o
);

  always_comb begin
    state_d_o = state_i;
    if (stop_i) begin
      state_d_o = StIdle;
    end else begin
      unique case (state_i)
        StIdle:   if (start_rise_i) state_d_o = StFetch;
        StFetch: begin
          if (!pend_i && grant_i && bus_err_i) state_d_o = StError;
          else if (pend_i && rdata_valid_i) state_d_o = bus_err_i ? StError : StDecode;
        end
        StDecode: begin
          if (!type_ok_i || len_misaligned_i) state_d_o = StError;
          else if (len_zero_i)                state_d_o = linked_i ? StLink : StStatus;
          else                                state_d_o = StRead;
        end
        StRead: begin
          if (!pend_i && grant_i && bus_err_i) state_d_o = StError;
          else if (pend_i && rdata_valid_i) state_d_o = bus_err_i ? StError : StWrite;
        end
        StWrite: begin
          if (grant_i) begin
            if (bus_err_i)         state_d_o = StError;
            else if (!last_chunk_i) state_d_o = StRead;
            else                   state_d_o = linked_i ? StLink : StStatus;
          end
        end
        StLink:   state_d_o = depth_max_i ? StError : StFetch;
        StError:  state_d_o = StStatus;
        StStatus: if (grant_i) state_d_o = StDone;
        StDone:   state_d_o = StIdle;
        default:  state_d_o = StIdle;
      endcase
    end
  end

  // A request stays up until granted; pend marks the wait for the read data beat.
  always_comb begin
    pend_d_o      = pend_i;
    read_valid_o  = 1'b0;
    write_valid_o = 1'b0;
    busy_o        = 1'b0;
    irq_o         = 1'b0;
    accept_o      = 1'b0;
    desc_load_o   = 1'b0;
    buf_load_o    = 1'b0;
    advance_o     = 1'b0;
    link_load_o   = 1'b0;
    err_set_o     = 1'b0;
    if (stop_i) begin
      pend_d_o = 1'b0;
    end else begin
      unique case (state_i)
        StIdle: begin
          pend_d_o = 1'b0;
          accept_o = start_rise_i;
        end
        StFetch, StRead: begin
          busy_o       = 1'b1;
          read_valid_o = !pend_i;
          if (!pend_i && grant_i && !bus_err_i) pend_d_o = 1'b1;
          if (pend_i && rdata_valid_i) begin
            pend_d_o = 1'b0;
            if (state_i == StFetch) desc_load_o = !bus_err_i;
            else                    buf_load_o  = !bus_err_i;
          end
        end
        StWrite: begin
          busy_o        = 1'b1;
          write_valid_o = 1'b1;
          advance_o     = grant_i && !bus_err_i;
        end
        StLink: begin
          busy_o      = 1'b1;
          link_load_o = !depth_max_i;
        end
        StError: begin
          busy_o    = 1'b1;
          err_set_o = 1'b1;
        end
        StStatus: begin
          busy_o        = 1'b1;
          write_valid_o = 1'b1;
        end
        StDecode: busy_o = 1'b1;
        StDone:   irq_o  = 1'b1;
        default:  ;
      endcase
    end
  end

endmodule

// File: rtl/ip_codma.sv
// Descriptor-driven copy DMA: fetches a task, copies in 8B/32B chunks, follows links and
// writes a status word before pulsing irq.
module ip_codma
  import ip_codma_states_pkg::*;
(
  input logic             clk_i,
  input logic             reset_n_i,
  ip_codma_cpu_if.slave   cpu_if,
  ip_codma_bus_if.master  bus_if
);

  dma_state_t        state_q, state_d;
  logic              start_q, pend_q, pend_d, err_q;
  logic [ADDR_W-1:0] fetch_ptr_q, status_ptr_q, src_q, dest_q, link_q;
  logic [31:0]       type_q, rem_q, chunk;
  logic [2:0]        depth_q;
  logic [DATA_W-1:0] buf_q;

  logic accept, desc_load, buf_load, advance, link_load, err_set;
  logic chunk32, len_misaligned;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        size;
  logic [DATA_W-1:0] wdata;
  desc_t             desc;

  assign desc           = desc_t'(bus_if.read_data[$bits(desc_t)-1:0]);
  assign chunk          = chunk_bytes(type_q);
  assign chunk32        = (chunk == 32'd32);
  assign len_misaligned = chunk32 ? (|rem_q[4:0]) : (|rem_q[2:0]);

  ip_codma_main_machine u_main_machine (
    .state_i          (state_q),
    .pend_i           (pend_q),
    .start_rise_i     (cpu_if.start & ~start_q),
    .stop_i           (cpu_if.stop),
    .grant_i          (bus_if.grant),
    .rdata_valid_i    (bus_if.read_data_valid),
    .bus_err_i        (bus_if.error),
    .type_ok_i        (task_valid(type_q)),
    .len_zero_i       (rem_q == 32'd0),
    .len_misaligned_i (len_misaligned),
    .last_chunk_i     (rem_q == chunk),
    .linked_i         (task_linked(type_q)),
    .depth_max_i      (depth_q >= MAX_DEPTH),
    .state_d_o        (state_d),
    .pend_d_o         (pend_d),
    .read_valid_o     (bus_if.read_valid),
    .write_valid_o    (bus_if.write_valid),
    .busy_o           (cpu_if.busy),
    .irq_o            (cpu_if.irq),
    .accept_o         (accept),
    .desc_load_o      (desc_load),
    .buf_load_o       (buf_load),
    .advance_o        (advance),
    .link_load_o      (link_load),
    .err_set_o        (err_set)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= StIdle;
    else            state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      start_q      <= 1'b0;
      pend_q       <= 1'b0;
      err_q        <= 1'b0;
      fetch_ptr_q  <= '0;
      status_ptr_q <= '0;
      src_q        <= '0;
      dest_q       <= '0;
      link_q       <= '0;
      type_q       <= '0;
      rem_q        <= '0;
      depth_q      <= '0;
      buf_q        <= '0;
    end else begin
      start_q <= cpu_if.start;
      pend_q  <= pend_d;
      // Pointers are captured once so CPU-side changes cannot disturb a running task.
      if (accept) begin
        fetch_ptr_q  <= cpu_if.task_pointer;
        status_ptr_q <= cpu_if.status_pointer;
        depth_q      <= '0;
        err_q        <= 1'b0;
      end
      if (link_load) fetch_ptr_q <= link_q;
      if (desc_load) begin
        type_q  <= desc.task_type;
        rem_q   <= desc.len_bytes;
        src_q   <= desc.src;
        dest_q  <= desc.dest;
        link_q  <= desc.link;
        depth_q <= depth_q + 3'd1;
      end
      if (buf_load) buf_q <= bus_if.read_data;
      if (advance) begin
        src_q  <= src_q + chunk;
        dest_q <= dest_q + chunk;
        rem_q  <= rem_q - chunk;
      end
      if (err_set) err_q <= 1'b1;
    end
  end

  always_comb begin
    addr  = '0;
    size  = SIZE_8B;
    wdata = '0;
    case (state_q)
      StFetch: begin
        addr = fetch_ptr_q;
        size = SIZE_32B;
      end
      StRead: begin
        addr = src_q;
        size = chunk32 ? SIZE_32B : SIZE_8B;
      end
      StWrite: begin
        addr  = dest_q;
        size  = chunk32 ? SIZE_32B : SIZE_8B;
        wdata = chunk32 ? buf_q : {{(DATA_W-64){1'b0}}, buf_q[63:0]};
      end
      StStatus: begin
        addr  = status_ptr_q;
        wdata = {{(DATA_W-64){1'b0}}, (err_q ? STATUS_ERR : STATUS_OK)};
      end
      default: ;
    endcase
  end

  assign bus_if.addr       = addr;
  assign bus_if.size       = size;
  assign bus_if.write_data = wdata;

endmodule

// File: tb/tb_ip_codma.sv
// Directed bench for ip_codma against a 32 x 64-bit pipelined memory that grants every other
// cycle and flags accesses beyond byte 255.
module tb_ip_codma;

  logic clk;
  logic reset_n;
  int   pass_cnt = 0;
  int   check_cnt = 0;
  int   irq_cnt = 0;
  int   writes_seen = 0;
  int   reads_seen = 0;

  logic [63:0]  mem [32];
  logic         gnt_en, host_we, rp1, req, oor;
  logic [4:0]   host_idx;
  logic [63:0]  host_data;
  logic [255:0] rd1, rtmp;

  ip_codma_cpu_if cpu ();
  ip_codma_bus_if bus ();

  ip_codma dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .cpu_if    (cpu),
    .bus_if    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign req       = bus.read_valid | bus.write_valid;
  assign oor       = ({1'b0, bus.addr} + ((bus.size != 2'd0) ? 33'd32 : 33'd8)) > 33'd256;
  assign bus.grant = req & gnt_en;
  assign bus.error = req & gnt_en & oor;

  always @(posedge clk) begin
    if (!reset_n) begin
      gnt_en              <= 1'b0;
      rp1                 <= 1'b0;
      rd1                 <= '0;
      bus.read_data_valid <= 1'b0;
      bus.read_data       <= '0;
    end else begin
      gnt_en              <= ~gnt_en;
      rp1                 <= 1'b0;
      bus.read_data_valid <= rp1;
      bus.read_data       <= rd1;
      if (host_we) mem[host_idx] = host_data;
      if (bus.grant && !bus.error) begin
        if (bus.write_valid) begin
          writes_seen++;
          if (bus.size != 2'd0)
            for (int k = 0; k < 4; k++) mem[bus.addr[7:3] + 5'(k)] = bus.write_data[64*k +: 64];
          else
            mem[bus.addr[7:3]] = bus.write_data[63:0];
        end else begin
          reads_seen++;
          rtmp = '0;
          if (bus.size != 2'd0)
            for (int k = 0; k < 4; k++) rtmp[64*k +: 64] = mem[bus.addr[7:3] + 5'(k)];
          else
            rtmp[63:0] = mem[bus.addr[7:3]];
          rp1 <= 1'b1;
          rd1 <= rtmp;
        end
      end
    end
  end

  always @(negedge clk) if (cpu.irq === 1'b1) irq_cnt++;

  function automatic logic [63:0] pat(input int i);
    return {32'hC0DE_0000 + 32'(i), 32'h5A00_0000 + 32'(i * 7)};
  endfunction

  task automatic poke(input int idx, input logic [63:0] d);
    host_idx  = 5'(idx);
    host_data = d;
    host_we   = 1'b1;
    @(negedge clk);
    host_we   = 1'b0;
  endtask

  task automatic load_pattern();
    for (int i = 0; i < 32; i++) poke(i, pat(i));
  endtask

  task automatic load_desc(input int w, input logic [31:0] ttype, len, src, dest, link);
    poke(w, {len, ttype});
    poke(w + 1, {dest, src});
    poke(w + 2, {32'h0, link});
  endtask

  // Start pulse; pointers are scrambled afterwards so only the latched copies can work.
  task automatic kick(input logic [31:0] tp, input logic [31:0] sp);
    cpu.task_pointer   = tp;
    cpu.status_pointer = sp;
    cpu.start          = 1'b1;
    @(negedge clk);
    cpu.start          = 1'b0;
    cpu.task_pointer   = 32'hFFFF_FF00;
    cpu.status_pointer = 32'hFFFF_FF00;
  endtask

  task automatic wait_irq(output bit seen, output logic busy_at);
    seen    = 1'b0;
    busy_at = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (cpu.irq === 1'b1) begin
        seen    = 1'b1;
        busy_at = cpu.busy;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check_cnt++;
    if ({cpu.busy, cpu.irq, bus.read_valid, bus.write_valid, bus.size, bus.addr} !== 38'd0)
      $display("FAIL reset_ctrl: got %b want 0",
               {cpu.busy, cpu.irq, bus.read_valid, bus.write_valid, bus.size, bus.addr});
    else pass_cnt++;
    check_cnt++;
    if (bus.write_data !== 256'd0) $display("FAIL reset_wdata: got %h want 0", bus.write_data);
    else pass_cnt++;
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_type0();
    int i0, w0, r0;
    bit seen;
    logic busy_at;
    load_pattern();
    load_desc(24, 32'd0, 32'd16, 32'h40, 32'h80, 32'd0);
    i0 = irq_cnt; w0 = writes_seen; r0 = reads_seen;
    kick(32'hC0, 32'hF8);
    check_cnt++;
    if (cpu.busy !== 1'b1) $display("FAIL t0_busy_start: got %b want 1", cpu.busy);
    else pass_cnt++;
    wait_irq(seen, busy_at);
    check_cnt++;
    if (seen !== 1'b1 || busy_at !== 1'b0)
      $display("FAIL t0_irq: seen %b busy %b want 1 0", seen, busy_at);
    else pass_cnt++;
    repeat (3) @(negedge clk);
    check_cnt++;
    if (irq_cnt - i0 !== 1) $display("FAIL t0_irq_count: got %0d want 1", irq_cnt - i0);
    else pass_cnt++;
    check_cnt++;
    if (mem[16] !== pat(8) || mem[17] !== pat(9))
      $display("FAIL t0_data: got %h %h want %h %h", mem[16], mem[17], pat(8), pat(9));
    else pass_cnt++;
    check_cnt++;
    if (mem[18] !== pat(18)) $display("FAIL t0_no_overrun: got %h want %h", mem[18], pat(18));
    else pass_cnt++;
    check_cnt++;
    if (mem[31] !== 64'd0) $display("FAIL t0_status: got %h want 0", mem[31]);
    else pass_cnt++;
    check_cnt++;
    if (writes_seen - w0 !== 3 || reads_seen - r0 !== 3 || cpu.busy !== 1'b0)
      $display("FAIL t0_traffic: wr %0d rd %0d busy %b want 3 3 0",
               writes_seen - w0, reads_seen - r0, cpu.busy);
    else pass_cnt++;
  endtask

  task automatic test_type1();
    int i0, w0, r0;
    bit seen;
    logic busy_at;
    load_pattern();
    load_desc(24, 32'd1, 32'd96, 32'h00, 32'h60, 32'd0);
    i0 = irq_cnt; w0 = writes_seen; r0 = reads_seen;
    kick(32'hC0, 32'hF8);
    wait_irq(seen, busy_at);
    check_cnt++;
    if (seen !== 1'b1 || busy_at !== 1'b0)
      $display("FAIL t1_irq: seen %b busy %b want 1 0", seen, busy_at);
    else pass_cnt++;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 12; k++) begin
      check_cnt++;
      if (mem[12+k] !== pat(k)) $display("FAIL t1_data_%0d: got %h want %h", k, mem[12+k], pat(k));
      else pass_cnt++;
    end
    check_cnt++;
    if (mem[31] !== 64'd0 || irq_cnt - i0 !== 1)
      $display("FAIL t1_status: got %h irqs %0d want 0 1", mem[31], irq_cnt - i0);
    else pass_cnt++;
    check_cnt++;
    if (writes_seen - w0 !== 4 || reads_seen - r0 !== 4)
      $display("FAIL t1_traffic: wr %0d rd %0d want 4 4", writes_seen - w0, reads_seen - r0);
    else pass_cnt++;
  endtask

  task automatic test_link();
    int i0, w0, r0;
    bit seen;
    logic busy_at;
    load_pattern();
    load_desc(24, 32'd2, 32'd32, 32'h00, 32'h20, 32'hE0);
    load_desc(28, 32'd0, 32'd8, 32'h40, 32'h60, 32'd0);
    i0 = irq_cnt; w0 = writes_seen; r0 = reads_seen;
    kick(32'hC0, 32'hF8);
    wait_irq(seen, busy_at);
    check_cnt++;
    if (seen !== 1'b1) $display("FAIL lk_irq: got %b want 1", seen);
    else pass_cnt++;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check_cnt++;
      if (mem[4+k] !== pat(k)) $display("FAIL lk_first_%0d: got %h want %h", k, mem[4+k], pat(k));
      else pass_cnt++;
    end
    check_cnt++;
    if (mem[12] !== pat(8) || mem[13] !== pat(13))
      $display("FAIL lk_second: got %h %h want %h %h", mem[12], mem[13], pat(8), pat(13));
    else pass_cnt++;
    check_cnt++;
    if (mem[31] !== 64'd0 || irq_cnt - i0 !== 1)
      $display("FAIL lk_status: got %h irqs %0d want 0 1", mem[31], irq_cnt - i0);
    else pass_cnt++;
    check_cnt++;
    if (writes_seen - w0 !== 3 || reads_seen - r0 !== 4)
      $display("FAIL lk_traffic: wr %0d rd %0d want 3 4", writes_seen - w0, reads_seen - r0);
    else pass_cnt++;
  endtask

  task automatic test_bus_error();
    int i0, w0, r0;
    bit seen;
    logic busy_at;
    load_pattern();
    i0 = irq_cnt; w0 = writes_seen; r0 = reads_seen;
    kick(32'd256, 32'hF8);
    wait_irq(seen, busy_at);
    check_cnt++;
    if (seen !== 1'b1 || busy_at !== 1'b0)
      $display("FAIL be_irq: seen %b busy %b want 1 0", seen, busy_at);
    else pass_cnt++;
    repeat (3) @(negedge clk);
    check_cnt++;
    if (mem[31] !== 64'd1) $display("FAIL be_status: got %h want 1", mem[31]);
    else pass_cnt++;
    check_cnt++;
    if (writes_seen - w0 !== 1 || reads_seen - r0 !== 0 || irq_cnt - i0 !== 1)
      $display("FAIL be_traffic: wr %0d rd %0d irqs %0d want 1 0 1",
               writes_seen - w0, reads_seen - r0, irq_cnt - i0);
    else pass_cnt++;
  endtask

  task automatic test_bad_type();
    int w0;
    bit seen;
    logic busy_at;
    load_pattern();
    load_desc(24, 32'hF, 32'd8, 32'h40, 32'h80, 32'd0);
    w0 = writes_seen;
    kick(32'hC0, 32'hF8);
    wait_irq(seen, busy_at);
    check_cnt++;
    if (seen !== 1'b1) $display("FAIL bt_irq: got %b want 1", seen);
    else pass_cnt++;
    repeat (3) @(negedge clk);
    check_cnt++;
    if (mem[31] !== 64'd1) $display("FAIL bt_status: got %h want 1", mem[31]);
    else pass_cnt++;
    check_cnt++;
    if (mem[16] !== pat(16) || writes_seen - w0 !== 1)
      $display("FAIL bt_no_copy: got %h wr %0d want %h 1", mem[16], writes_seen - w0, pat(16));
    else pass_cnt++;
  endtask

  task automatic test_stop();
    int i0;
    bit seen;
    logic busy_at;
    load_pattern();
    load_desc(24, 32'd1, 32'd96, 32'h00, 32'h60, 32'd0);
    poke(31, 64'hDEAD_BEEF_0BAD_F00D);
    i0 = irq_cnt;
    kick(32'hC0, 32'hF8);
    repeat (9) @(negedge clk);
    check_cnt++;
    if (cpu.busy !== 1'b1) $display("FAIL st_busy_before: got %b want 1", cpu.busy);
    else pass_cnt++;
    cpu.stop = 1'b1;
    @(negedge clk);
    cpu.stop = 1'b0;
    check_cnt++;
    if (cpu.busy !== 1'b0 || bus.read_valid !== 1'b0 || bus.write_valid !== 1'b0)
      $display("FAIL st_abort: busy %b rv %b wv %b want 0 0 0",
               cpu.busy, bus.read_valid, bus.write_valid);
    else pass_cnt++;
    repeat (30) @(negedge clk);
    check_cnt++;
    if (irq_cnt !== i0 || mem[31] !== 64'hDEAD_BEEF_0BAD_F00D)
      $display("FAIL st_quiet: irqs %0d status %h want 0 deadbeef0badf00d", irq_cnt - i0, mem[31]);
    else pass_cnt++;
    load_desc(24, 32'd0, 32'd16, 32'h40, 32'h80, 32'd0);
    kick(32'hC0, 32'hF8);
    wait_irq(seen, busy_at);
    check_cnt++;
    if (seen !== 1'b1) $display("FAIL st_restart_irq: got %b want 1", seen);
    else pass_cnt++;
    repeat (3) @(negedge clk);
    check_cnt++;
    if (mem[31] !== 64'd0 || mem[16] !== pat(8) || mem[17] !== pat(9))
      $display("FAIL st_restart_data: status %h d %h %h want 0 %h %h",
               mem[31], mem[16], mem[17], pat(8), pat(9));
    else pass_cnt++;
  endtask

  initial begin
    host_we            = 1'b0;
    host_idx           = '0;
    host_data          = '0;
    cpu.start          = 1'b0;
    cpu.stop           = 1'b0;
    cpu.task_pointer   = '0;
    cpu.status_pointer = '0;
    test_reset();
    test_type0();
    test_type1();
    test_link();
    test_bus_error();
    test_bad_type();
    test_stop();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
